// File: rtl/imm_ext_pkg.sv
// Shared types and constants for the immediate extender pipeline.
package imm_ext_pkg;

    typedef enum logic [1:0] {
        SEXT     = 2'b00,
        ZEXT     = 2'b01,
        SEXT_SHL = 2'b10,
        UPPER    = 2'b11
    } imm_mode_t;

    localparam int IMM_FIFO_DEPTH = 2;
    localparam int IMM_CNT_W      = $clog2(IMM_FIFO_DEPTH + 1);
    localparam int IMM_PTR_W      = $clog2(IMM_FIFO_DEPTH);

endpackage

// File: rtl/imm_ext_fifo2.sv
// Generic 2-entry valid/ready buffer; storage is cleared on reset so the
// head reads as zero while empty after reset.
module imm_ext_fifo2
    import imm_ext_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0]         mem [IMM_FIFO_DEPTH];
    logic [IMM_PTR_W-1:0] head;
    logic [IMM_PTR_W-1:0] tail;
    logic [IMM_CNT_W-1:0] count;
    logic                 push;
    logic                 pop;

    // Gated by rst so upstream sees "not ready" for the whole reset window.
    assign in_ready  = rst && (count < IMM_CNT_W'(IMM_FIFO_DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[head];

    always_ff @(posedge clk) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < IMM_FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[tail] <= in_data;
                tail      <= tail + 1'b1;
            end
            if (pop) head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Immediate extender (SEXT/ZEXT/SEXT_SHL/UPPER) feeding a 2-entry output buffer.
// Define IMM_EXT_OVF_EN to add the out_ovf port and its per-entry storage.
module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 6,
    parameter int OUT_W = 10,
    parameter int SHIFT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
`ifdef IMM_EXT_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    generate
        if (IN_W < 1 || OUT_W < IN_W) begin : g_bad_params
            $error("imm_ext_pipe: need IN_W >= 1 and OUT_W >= IN_W");
        end
    endgenerate

    imm_mode_t        mode;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] shl;
    logic [OUT_W-1:0] ext;

    assign mode = imm_mode_t'(in_mode);
    assign sext = OUT_W'($signed(in_imm));

`ifdef IMM_EXT_OVF_EN
    localparam int WIDE_W = OUT_W + IN_W + SHIFT;
    localparam int ENT_W  = OUT_W + 1;

    logic [WIDE_W-1:0] shl_wide;
    logic              shl_ovf;
    logic              ext_ovf;

    // Full-precision shift; overflow means the dropped bits are not a pure
    // sign extension of the kept MSB.
    assign shl_wide = WIDE_W'($signed(in_imm)) << SHIFT;
    assign shl      = shl_wide[OUT_W-1:0];
    assign shl_ovf  = shl_wide[WIDE_W-1:OUT_W] != {(WIDE_W-OUT_W){shl_wide[OUT_W-1]}};
    assign ext_ovf  = (mode == SEXT_SHL) && shl_ovf;
`else
    localparam int ENT_W = OUT_W;

    assign shl = sext << SHIFT;
`endif

    always_comb begin
        ext = '0;
        case (mode)
            SEXT:     ext = sext;
            ZEXT:     ext = OUT_W'(in_imm);
            SEXT_SHL: ext = shl;
            UPPER:    ext = OUT_W'(in_imm) << (OUT_W - IN_W);
            default:  ext = '0;
        endcase
    end

    logic [ENT_W-1:0] fifo_in;
    logic [ENT_W-1:0] fifo_out;

`ifdef IMM_EXT_OVF_EN
    assign fifo_in             = {ext_ovf, ext};
    assign {out_ovf, out_data} = fifo_out;
`else
    assign fifo_in  = ext;
    assign out_data = fifo_out;
`endif

    imm_ext_fifo2 #(
        .W(ENT_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (fifo_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (fifo_out)
    );

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: default-width and OUT_W=7 instances share one
// handshake; an arithmetic queue model supplies all expected values.
module tb_imm_ext_pipe;
    import imm_ext_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [5:0] in_imm = '0;
    logic [1:0] in_mode = '0;
    logic       in_ready, out_valid, in_ready7, out_valid7;
    logic [9:0] out_data;
    logic [6:0] out_data7;
`ifdef IMM_EXT_OVF_EN
    logic       out_ovf, out_ovf7;
`endif

    always #5 clk = ~clk;

    imm_ext_pipe #(.IN_W(6), .OUT_W(10), .SHIFT(2)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_mode(in_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data)
`ifdef IMM_EXT_OVF_EN
        , .out_ovf(out_ovf)
`endif
    );

    imm_ext_pipe #(.IN_W(6), .OUT_W(7), .SHIFT(2)) u_dut7 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready7),
        .in_imm(in_imm), .in_mode(in_mode), .out_valid(out_valid7),
        .out_ready(out_ready), .out_data(out_data7)
`ifdef IMM_EXT_OVF_EN
        , .out_ovf(out_ovf7)
`endif
    );

    typedef struct {
        logic [9:0] d10;
        logic [6:0] d7;
        logic       o10;
        logic       o7;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   passed = 0;
    int   fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Extension as integer arithmetic on the immediate's numeric value.
    function automatic longint ext_val(input longint s, input longint u, input logic [1:0] mode,
                                       input int ow, output logic ovf);
        longint m = longint'(1) << ow;
        longint r;
        ovf = 1'b0;
        case (mode)
            2'd0:    r = s;
            2'd1:    r = u;
            2'd2: begin
                r   = s * 4;
                ovf = (r >= m / 2) || (r < -(m / 2));
            end
            default: r = u * (longint'(1) << (ow - 6));
        endcase
        return ((r % m) + m) % m;
    endfunction

    function automatic ent_t make_entry(input logic [5:0] imm, input logic [1:0] mode);
        ent_t   e;
        longint u = longint'(imm);
        longint s = imm[5] ? u - 64 : u;
        e.d10 = 10'(ext_val(s, u, mode, 10, e.o10));
        e.d7  = 7'(ext_val(s, u, mode, 7, e.o7));
        return e;
    endfunction

    task automatic check_outputs(input logic rs);
        chk("in_ready", 32'(in_ready), 32'(rs && q.size() < 2));
        chk("in_ready7", 32'(in_ready7), 32'(rs && q.size() < 2));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("out_valid7", 32'(out_valid7), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_data", 32'(out_data), 32'(q[0].d10));
            chk("out_data7", 32'(out_data7), 32'(q[0].d7));
`ifdef IMM_EXT_OVF_EN
            chk("out_ovf", 32'(out_ovf), 32'(q[0].o10));
            chk("out_ovf7", 32'(out_ovf7), 32'(q[0].o7));
`endif
        end
    endtask

    task automatic step(input logic v, input logic [5:0] imm, input logic [1:0] mode,
                        input logic ordy, input logic rs);
        ent_t e;
        logic acc, popd;
        @(negedge clk);
        in_valid = v; in_imm = imm; in_mode = mode; out_ready = ordy; rst = rs;
        #1 check_outputs(rs);
        acc  = rs && v && (q.size() < 2);
        popd = rs && ordy && (q.size() != 0);
        e    = make_entry(imm, mode);
        @(posedge clk);
        if (!rs) q.delete();
        else begin
            if (popd) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
    endtask

    // Single beat with out_ready high, then compare against a fixed constant.
    task automatic beat(input string tag, input logic [5:0] imm, input logic [1:0] mode,
                        input logic [9:0] e10, input logic [6:0] e7, input logic eo7);
        step(1'b1, imm, mode, 1'b1, 1'b1);
        #1;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_d10"}, 32'(out_data), 32'(e10));
        chk({tag, "_d7"}, 32'(out_data7), 32'(e7));
`ifdef IMM_EXT_OVF_EN
        chk({tag, "_ovf10"}, 32'(out_ovf), 32'd0);
        chk({tag, "_ovf7"}, 32'(out_ovf7), 32'(eo7));
`else
        if (eo7 === 1'bx) chk({tag, "_eo7"}, 32'(eo7), 32'd0);
`endif
    endtask

    initial begin
        // Reset window
        step(1'b0, 6'd0, 2'd0, 1'b0, 1'b0);
        step(1'b0, 6'd0, 2'd0, 1'b0, 1'b0);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);

        // Directed transforms
        beat("sext_pos", 6'b000111, SEXT,     10'h007, 7'h07, 1'b0);
        beat("sext_neg", 6'b101010, SEXT,     10'h3EA, 7'h6A, 1'b0);
        beat("zext",     6'b101010, ZEXT,     10'h02A, 7'h2A, 1'b0);
        beat("upper",    6'b000111, UPPER,    10'h070, 7'h0E, 1'b0);
        beat("shl_neg",  6'b101010, SEXT_SHL, 10'h3A8, 7'h28, 1'b1);
        beat("shl_ovf",  6'b011111, SEXT_SHL, 10'h07C, 7'h7C, 1'b1);
        beat("shl_m1",   6'b111111, SEXT_SHL, 10'h3FC, 7'h7C, 1'b0);
        step(1'b0, 6'd0, 2'd0, 1'b1, 1'b1);

        // Backpressure: beats 1,2 absorbed, 3 held until space frees
        step(1'b1, 6'd1, ZEXT, 1'b0, 1'b1);
        step(1'b1, 6'd2, ZEXT, 1'b0, 1'b1);
        step(1'b1, 6'd3, ZEXT, 1'b0, 1'b1);
        #1;
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        chk("bp_head", 32'(out_data), 32'd1);
        step(1'b1, 6'd3, ZEXT, 1'b1, 1'b1);
        #1;
        chk("bp_second", 32'(out_data), 32'd2);
        step(1'b1, 6'd3, ZEXT, 1'b1, 1'b1);
        #1;
        chk("bp_third", 32'(out_data), 32'd3);
        step(1'b0, 6'd0, ZEXT, 1'b1, 1'b1);
        #1;
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Reset while full
        step(1'b1, 6'd5, SEXT, 1'b0, 1'b1);
        step(1'b1, 6'd6, SEXT, 1'b0, 1'b1);
        step(1'b0, 6'd0, SEXT, 1'b0, 1'b0);
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 6'd0, SEXT, 1'b1, 1'b1);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 3) != 0), 6'($urandom), 2'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 49) != 0));
        end
        step(1'b0, 6'd0, 2'd0, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
